// File: rtl/multi_line_cache.sv
// multi_line_cache: direct-mapped, write-through, no-write-allocate line cache
// between a single-outstanding core request port and MUSKBUS.
// Optional feature macro: MULTI_LINE_CACHE_STATS_EN adds saturating
// hit_count / miss_count outputs.

package CACHE;
    typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, FLUSH = 2'd2} cmd_t;
endpackage

package MUSKBUS;
    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } req_t;
    typedef struct packed {
        logic        cyc;
        logic [63:0] data;
    } resp_t;
endpackage

module multi_line_cache #(
    parameter int NUM_LINES  = 8,
    parameter int LINE_BYTES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            reqcyc,
    input  CACHE::cmd_t     cmd,
    input  logic [63:0]     req_addr,
    input  logic [63:0]     req_data,
    output logic            respcyc,
    output logic [63:0]     resp_data,
    output MUSKBUS::req_t   bus_req,
    input  logic            bus_reqack,
    input  MUSKBUS::resp_t  bus_resp,
    output logic            bus_respack
`ifdef MULTI_LINE_CACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);
    localparam int WORDS = LINE_BYTES / 8;
    localparam int OFF_W = $clog2(WORDS);
    localparam int CW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 64 - 3 - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_DATA, WR_REQ, RESP} state_t;
    state_t state, state_nx;

    logic [63:0]      mem  [NUM_LINES][WORDS];
    logic [TAG_W-1:0] tags [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [CW-1:0]    cnt;
    logic [63:0]      rdata;

    logic [CW-1:0]    off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit, beat, last, accept;
    logic             unused_ok;

    // Request address is held stable for the whole transaction, so it is
    // decoded directly instead of being latched.
    assign off       = (OFF_W > 0) ? req_addr[3 +: CW] : '0;
    assign idx       = req_addr[3 + OFF_W +: IDX_W];
    assign tag       = req_addr[63 -: TAG_W];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign accept    = (state == IDLE) && reqcyc;
    assign beat      = (state == FILL_DATA) && bus_resp.cyc;
    assign last      = (cnt == CW'(WORDS - 1));
    assign resp_data = respcyc ? rdata : 64'd0;
    assign unused_ok = ^req_addr[2:0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and bus/response outputs; bus fields stay 0 unless cyc is up
    always_comb begin
        state_nx    = state;
        bus_req     = '0;
        bus_respack = 1'b0;
        respcyc     = 1'b0;
        case (state)
            IDLE: begin
                if (reqcyc) begin
                    case (cmd)
                        CACHE::READ:  state_nx = hit ? RESP : FILL_REQ;
                        CACHE::WRITE: state_nx = WR_REQ;
                        CACHE::FLUSH: state_nx = RESP;
                        default:      state_nx = IDLE;
                    endcase
                end
            end
            FILL_REQ: begin
                bus_req.cyc  = 1'b1;
                bus_req.addr = req_addr & ~64'(LINE_BYTES - 1);
                if (bus_reqack) state_nx = FILL_DATA;
            end
            FILL_DATA: begin
                bus_respack = bus_resp.cyc;
                if (beat && last) state_nx = RESP;
            end
            WR_REQ: begin
                bus_req.cyc  = 1'b1;
                bus_req.we   = 1'b1;
                bus_req.addr = {req_addr[63:3], 3'b000};
                bus_req.data = req_data;
                if (bus_reqack) state_nx = RESP;
            end
            RESP: begin
                respcyc  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Valid bits, beat counter and the response word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (accept) begin
                case (cmd)
                    CACHE::READ: begin
                        if (hit) rdata <= mem[idx][off];
                        // line is being replaced: never leave it half-valid
                        else     valid[idx] <= 1'b0;
                    end
                    CACHE::WRITE: rdata <= '0;
                    CACHE::FLUSH: begin
                        valid <= '0;
                        rdata <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == FILL_REQ) cnt <= '0;
            if (beat) begin
                if (cnt == off) rdata <= bus_resp.data;
                if (last) begin
                    valid[idx] <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Line data and tags; contents are don't-care while the valid bit is 0
    always_ff @(posedge clk) begin
        if (beat)
            mem[idx][cnt] <= bus_resp.data;
        else if (accept && cmd == CACHE::WRITE && hit)
            mem[idx][off] <= req_data;
        if (beat && last) tags[idx] <= tag;
    end

`ifdef MULTI_LINE_CACHE_STATS_EN
    logic rd_hit;

    // Saturating read hit/miss counters; hit is credited in the RESP cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hit     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            rd_hit <= accept && (cmd == CACHE::READ) && hit;
            if (state == RESP && rd_hit && hit_count != '1)
                hit_count <= hit_count + 32'd1;
            if (accept && state_nx == FILL_REQ && miss_count != '1)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
